// File: rtl/ebpc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ebpc_pkg
// Description : Shared types for the zero run-length encoder: FSM state enum,
//               output code struct and code-building helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package ebpc_pkg;

    // Struct fields are sized for the widest supported configuration
    // (DATA_W, RUN_W <= 31); the encoder exposes only the low CODE_W/LEN_W bits.
    localparam int unsigned ZRLE_CODE_W_MAX = 32;
    localparam int unsigned ZRLE_LEN_W_MAX  = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SPLIT = 2'd2
    } zrle_state_t;

    typedef struct packed {
        logic [ZRLE_CODE_W_MAX-1:0] code;
        logic [ZRLE_LEN_W_MAX-1:0]  len;
        logic                       last;
    } zrle_out_t;

    function automatic zrle_out_t zrle_value_code(
        input logic [ZRLE_CODE_W_MAX-1:0] value,
        input int unsigned                data_w,
        input logic                       last
    );
        zrle_out_t                  r;
        logic [ZRLE_CODE_W_MAX-1:0] one;
        one    = {{(ZRLE_CODE_W_MAX-1){1'b0}}, 1'b1};
        r.code = value | (one << data_w);
        r.len  = ZRLE_LEN_W_MAX'(data_w + 1);
        r.last = last;
        return r;
    endfunction

    // run_m1 is the run length minus one; the leading '0' flag is implicit.
    function automatic zrle_out_t zrle_run_code(
        input logic [ZRLE_CODE_W_MAX-1:0] run_m1,
        input int unsigned                run_w,
        input logic                       last
    );
        zrle_out_t r;
        r.code = run_m1;
        r.len  = ZRLE_LEN_W_MAX'(run_w + 1);
        r.last = last;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/zrle_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : zrle_encoder_if
// Description : Symbol-in / code-out handshake bundle of the ZRLE encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface zrle_encoder_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RUN_W  = 4
);
    localparam int unsigned CODE_W = ((DATA_W > RUN_W) ? DATA_W : RUN_W) + 1;
    localparam int unsigned LEN_W  = $clog2(CODE_W + 1);

    logic [DATA_W-1:0] data_i;
    logic              last_i;
    logic              vld_i;
    logic              rdy_o;
    logic [CODE_W-1:0] code_o;
    logic [LEN_W-1:0]  len_o;
    logic              last_o;
    logic              vld_o;
    logic              rdy_i;

    modport master (
        output data_i, last_i, vld_i, rdy_i,
        input  rdy_o, code_o, len_o, last_o, vld_o
    );

    modport slave (
        input  data_i, last_i, vld_i, rdy_i,
        output rdy_o, code_o, len_o, last_o, vld_o
    );
endinterface
`default_nettype wire

// File: rtl/fifo_slice.sv
`default_nettype none
// ============================================================================
// Module      : fifo_slice
// Description : Single-entry registered valid/ready slot; accepts a new item
//               in the same cycle the held one drains.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_slice #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid_i,
    input  T     data_i,
    output logic ready_o,
    output logic valid_o,
    output T     data_o,
    input  logic ready_i
);
    logic r_valid;
    T     r_data;

    assign ready_o = !r_valid || ready_i;
    assign valid_o = r_valid;
    assign data_o  = r_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (valid_i && ready_o) begin
            r_valid <= 1'b1;
            r_data  <= data_i;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/zrle_encoder.sv
`default_nettype none
// ============================================================================
// Module      : zrle_encoder
// Description : Zero run-length encoder; nonzero symbols become {1,v}, zero
//               runs become {0,n-1}, delivered through a one-entry output slot.
// Revision    : 1.0 - initial release
// ============================================================================
module zrle_encoder
    import ebpc_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RUN_W  = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    zrle_encoder_if.slave  bus
);
    localparam int unsigned CODE_W  = ((DATA_W > RUN_W) ? DATA_W : RUN_W) + 1;
    localparam int unsigned LEN_W   = $clog2(CODE_W + 1);
    localparam int unsigned MAX_RUN = 2 ** RUN_W;

    zrle_state_t       r_state;
    logic [RUN_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_pend_data;
    logic              r_pend_last;

    logic      w_out_free;
    logic      w_accept;
    logic      w_zero;
    logic      w_run_full;
    logic      w_emit;
    zrle_out_t w_emit_code;
    logic      w_slot_vld;
    zrle_out_t w_slot;

    logic [RUN_W:0]                w_cnt_inc;
    logic [ZRLE_CODE_W_MAX-1:0]    w_data_ext;
    logic [ZRLE_CODE_W_MAX-1:0]    w_pend_ext;
    logic [ZRLE_CODE_W_MAX-1:0]    w_cnt_ext;
    logic [ZRLE_CODE_W_MAX-1:0]    w_cnt_dec_ext;

    assign bus.rdy_o = w_out_free && (r_state != ST_SPLIT);
    assign w_accept  = bus.vld_i && bus.rdy_o;
    assign w_zero    = (bus.data_i == '0);

    assign w_cnt_inc     = {1'b0, r_cnt} + {{RUN_W{1'b0}}, 1'b1};
    assign w_run_full    = (w_cnt_inc == (RUN_W+1)'(MAX_RUN));
    assign w_data_ext    = ZRLE_CODE_W_MAX'(bus.data_i);
    assign w_pend_ext    = ZRLE_CODE_W_MAX'(r_pend_data);
    assign w_cnt_ext     = ZRLE_CODE_W_MAX'(r_cnt);
    assign w_cnt_dec_ext = ZRLE_CODE_W_MAX'(r_cnt - RUN_W'(1));

    // A run of n is coded as n-1, so run(cnt+1) carries r_cnt directly.
    always_comb begin
        w_emit      = 1'b0;
        w_emit_code = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_zero) begin
                        w_emit      = 1'b1;
                        w_emit_code = zrle_value_code(w_data_ext, DATA_W, bus.last_i);
                    end else if (bus.last_i) begin
                        w_emit      = 1'b1;
                        w_emit_code = zrle_run_code('0, RUN_W, 1'b1);
                    end
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    if (!w_zero) begin
                        w_emit      = 1'b1;
                        w_emit_code = zrle_run_code(w_cnt_dec_ext, RUN_W, 1'b0);
                    end else if (w_run_full || bus.last_i) begin
                        w_emit      = 1'b1;
                        w_emit_code = zrle_run_code(w_cnt_ext, RUN_W, bus.last_i);
                    end
                end
            end
            ST_SPLIT: begin
                if (w_out_free) begin
                    w_emit      = 1'b1;
                    w_emit_code = zrle_value_code(w_pend_ext, DATA_W, r_pend_last);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pend_data <= '0;
            r_pend_last <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_zero && !bus.last_i) begin
                        r_cnt   <= RUN_W'(1);
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        if (!w_zero) begin
                            r_pend_data <= bus.data_i;
                            r_pend_last <= bus.last_i;
                            r_cnt       <= '0;
                            r_state     <= ST_SPLIT;
                        end else if (w_run_full || bus.last_i) begin
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= w_cnt_inc[RUN_W-1:0];
                        end
                    end
                end
                ST_SPLIT: begin
                    if (w_out_free) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    fifo_slice #(
        .T (zrle_out_t)
    ) u_slot (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (w_emit),
        .data_i  (w_emit_code),
        .ready_o (w_out_free),
        .valid_o (w_slot_vld),
        .data_o  (w_slot),
        .ready_i (bus.rdy_i)
    );

    assign bus.vld_o  = w_slot_vld;
    assign bus.code_o = w_slot.code[CODE_W-1:0];
    assign bus.len_o  = w_slot.len[LEN_W-1:0];
    assign bus.last_o = w_slot.last;

    // Upper struct bits are always zero for this configuration.
    generate
        if (CODE_W < ZRLE_CODE_W_MAX) begin : g_code_pad
            logic w_unused_code;
            assign w_unused_code = ^w_slot.code[ZRLE_CODE_W_MAX-1:CODE_W];
        end
        if (LEN_W < ZRLE_LEN_W_MAX) begin : g_len_pad
            logic w_unused_len;
            assign w_unused_len = ^w_slot.len[ZRLE_LEN_W_MAX-1:LEN_W];
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_zrle_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_zrle_encoder
// Description : Directed self-checking bench for zrle_encoder (DATA_W=8, RUN_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_zrle_encoder;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned RUN_W  = 4;

    typedef struct packed {
        logic [31:0] cyc;
        logic [8:0]  code;
        logic [3:0]  len;
        logic        last;
    } obs_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cyc   = 32'd0;
    int          n_checks = 0;
    int          n_fail   = 0;
    obs_t        obs_q[$];

    always #5 clk = ~clk;

    zrle_encoder_if #(.DATA_W(DATA_W), .RUN_W(RUN_W)) bus ();

    zrle_encoder #(.DATA_W(DATA_W), .RUN_W(RUN_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always @(posedge clk) cyc <= cyc + 32'd1;

    always @(negedge clk)
        if (bus.vld_o && bus.rdy_i)
            obs_q.push_back({cyc, bus.code_o, bus.len_o, bus.last_o});

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [7:0] d, input logic l);
        int waited;
        bus.data_i = d;
        bus.last_i = l;
        bus.vld_i  = 1'b1;
        for (waited = 0; waited < 40; waited++) begin
            @(negedge clk);
            if (bus.rdy_o) break;
        end
        n_checks++;
        if (waited == 40) begin
            n_fail++;
            $display("FAIL send_timeout: rdy_o stayed 0 for 40 cycles, required 1 (data=%h)", d);
        end
        @(posedge clk);
        #1;
        bus.vld_i  = 1'b0;
        bus.last_i = 1'b0;
        bus.data_i = '0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.vld_i  = 1'b0;
        bus.data_i = '0;
        bus.last_i = 1'b0;
        bus.rdy_i  = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b, required 0", bus.vld_o); end
        n_checks++;
        if (bus.code_o !== 9'h000) begin n_fail++; $display("FAIL reset_code: got %h, required 000", bus.code_o); end
        n_checks++;
        if (bus.len_o !== 4'd0) begin n_fail++; $display("FAIL reset_len: got %0d, required 0", bus.len_o); end
        n_checks++;
        if (bus.last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b, required 0", bus.last_o); end
        n_checks++;
        if (bus.rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b, required 1", bus.rdy_o); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_mixed();
        logic [8:0] ec[3] = '{9'h105, 9'h001, 9'h107};
        logic [3:0] el[3] = '{4'd9, 4'd5, 4'd9};
        logic       et[3] = '{1'b0, 1'b0, 1'b1};
        obs_q.delete();
        send_sym(8'h05, 1'b0);
        send_sym(8'h00, 1'b0);
        send_sym(8'h00, 1'b0);
        send_sym(8'h07, 1'b1);
        idle(6);
        n_checks++;
        if (obs_q.size() != 3) begin n_fail++; $display("FAIL mixed_count: got %0d codes, required 3", obs_q.size()); end
        for (int i = 0; i < 3; i++) begin
            obs_t o;
            o = (i < obs_q.size()) ? obs_q[i] : '0;
            n_checks++;
            if (o.code !== ec[i] || o.len !== el[i] || o.last !== et[i]) begin
                n_fail++;
                $display("FAIL mixed_code[%0d]: got (%h,%0d,%b), required (%h,%0d,%b)",
                         i, o.code, o.len, o.last, ec[i], el[i], et[i]);
            end
        end
    endtask

    task automatic test_long_run();
        logic [8:0] ec[2] = '{9'h00F, 9'h003};
        logic       et[2] = '{1'b0, 1'b1};
        obs_q.delete();
        for (int i = 0; i < 20; i++) send_sym(8'h00, (i == 19));
        idle(5);
        n_checks++;
        if (obs_q.size() != 2) begin n_fail++; $display("FAIL long_run_count: got %0d codes, required 2", obs_q.size()); end
        for (int i = 0; i < 2; i++) begin
            obs_t o;
            o = (i < obs_q.size()) ? obs_q[i] : '0;
            n_checks++;
            if (o.code !== ec[i] || o.len !== 4'd5 || o.last !== et[i]) begin
                n_fail++;
                $display("FAIL long_run_code[%0d]: got (%h,%0d,%b), required (%h,5,%b)",
                         i, o.code, o.len, o.last, ec[i], et[i]);
            end
        end
    endtask

    task automatic test_max_run_then_value();
        obs_t o0, o1;
        obs_q.delete();
        for (int i = 0; i < 16; i++) send_sym(8'h00, 1'b0);
        send_sym(8'h03, 1'b1);
        idle(5);
        n_checks++;
        if (obs_q.size() != 2) begin n_fail++; $display("FAIL max_run_count: got %0d codes, required 2", obs_q.size()); end
        o0 = (obs_q.size() > 0) ? obs_q[0] : '0;
        o1 = (obs_q.size() > 1) ? obs_q[1] : '0;
        n_checks++;
        if (o0.code !== 9'h00F || o0.len !== 4'd5 || o0.last !== 1'b0) begin
            n_fail++;
            $display("FAIL max_run_code: got (%h,%0d,%b), required (00f,5,0)", o0.code, o0.len, o0.last);
        end
        n_checks++;
        if (o1.code !== 9'h103 || o1.len !== 4'd9 || o1.last !== 1'b1) begin
            n_fail++;
            $display("FAIL max_run_value: got (%h,%0d,%b), required (103,9,1)", o1.code, o1.len, o1.last);
        end
    endtask

    task automatic test_single_zero();
        obs_t o;
        obs_q.delete();
        send_sym(8'h00, 1'b1);
        idle(4);
        n_checks++;
        if (obs_q.size() != 1) begin n_fail++; $display("FAIL single_zero_count: got %0d codes, required 1", obs_q.size()); end
        o = (obs_q.size() > 0) ? obs_q[0] : '0;
        n_checks++;
        if (o.code !== 9'h000 || o.len !== 4'd5 || o.last !== 1'b1) begin
            n_fail++;
            $display("FAIL single_zero_code: got (%h,%0d,%b), required (000,5,1)", o.code, o.len, o.last);
        end
    endtask

    task automatic test_backpressure();
        obs_t o0, o1;
        obs_q.delete();
        bus.rdy_i = 1'b0;
        send_sym(8'h11, 1'b0);
        bus.data_i = 8'h22;
        bus.last_i = 1'b1;
        bus.vld_i  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rdy_o !== 1'b0) begin n_fail++; $display("FAIL bp_rdy[%0d]: got %b, required 0", i, bus.rdy_o); end
            n_checks++;
            if (bus.vld_o !== 1'b1) begin n_fail++; $display("FAIL bp_vld[%0d]: got %b, required 1", i, bus.vld_o); end
            n_checks++;
            if (bus.code_o !== 9'h111 || bus.len_o !== 4'd9 || bus.last_o !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got (%h,%0d,%b), required (111,9,0)", i, bus.code_o, bus.len_o, bus.last_o);
            end
        end
        @(posedge clk);
        #1 bus.rdy_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.rdy_o !== 1'b1) begin n_fail++; $display("FAIL bp_release_rdy: got %b, required 1", bus.rdy_o); end
        @(posedge clk);
        #1;
        bus.vld_i  = 1'b0;
        bus.last_i = 1'b0;
        bus.data_i = '0;
        idle(4);
        n_checks++;
        if (obs_q.size() != 2) begin n_fail++; $display("FAIL bp_count: got %0d codes, required 2", obs_q.size()); end
        o0 = (obs_q.size() > 0) ? obs_q[0] : '0;
        o1 = (obs_q.size() > 1) ? obs_q[1] : '0;
        n_checks++;
        if (o0.code !== 9'h111 || o0.last !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_first: got (%h,%b), required (111,0)", o0.code, o0.last);
        end
        n_checks++;
        if (o1.code !== 9'h122 || o1.last !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second: got (%h,%b), required (122,1)", o1.code, o1.last);
        end
    endtask

    task automatic test_reset_midrun();
        obs_t o;
        obs_q.delete();
        for (int i = 0; i < 3; i++) send_sym(8'h00, 1'b0);
        idle(2);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.vld_o !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_vld: got %b, required 0", bus.vld_o); end
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send_sym(8'h09, 1'b1);
        idle(5);
        n_checks++;
        if (obs_q.size() != 1) begin n_fail++; $display("FAIL midrun_count: got %0d codes, required 1", obs_q.size()); end
        o = (obs_q.size() > 0) ? obs_q[0] : '0;
        n_checks++;
        if (o.code !== 9'h109 || o.len !== 4'd9 || o.last !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_code: got (%h,%0d,%b), required (109,9,1)", o.code, o.len, o.last);
        end
    endtask

    task automatic test_back_to_back();
        obs_q.delete();
        for (int i = 0; i < 100; i++) send_sym(8'(i + 1), (i == 99));
        idle(5);
        n_checks++;
        if (obs_q.size() != 100) begin n_fail++; $display("FAIL b2b_count: got %0d codes, required 100", obs_q.size()); end
        if (obs_q.size() == 100) begin
            n_checks++;
            if (obs_q[99].cyc - obs_q[0].cyc !== 32'd99) begin
                n_fail++;
                $display("FAIL b2b_span: got %0d cycles, required 99", obs_q[99].cyc - obs_q[0].cyc);
            end
            for (int i = 0; i < 100; i++) begin
                logic [8:0] exp_code;
                exp_code = {1'b1, 8'(i + 1)};
                n_checks++;
                if (obs_q[i].code !== exp_code || obs_q[i].len !== 4'd9 || obs_q[i].last !== (i == 99)) begin
                    n_fail++;
                    $display("FAIL b2b_code[%0d]: got (%h,%0d,%b), required (%h,9,%b)",
                             i, obs_q[i].code, obs_q[i].len, obs_q[i].last, exp_code, (i == 99));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mixed();
        test_long_run();
        test_max_run_then_value();
        test_single_zero();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/zrle_encoder.md
ZRLE_ENCODER -- requirements
Module: zrle_encoder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the input symbol width in bits.
REQ-002 SHALL have parameter RUN_W, default 4, giving the run-length field width; MAX_RUN = 2**RUN_W; RUN_W >= 1.
REQ-003 SHALL derive CODE_W = max(DATA_W, RUN_W)+1 and LEN_W = clog2(CODE_W+1).
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk_i  in  1  clock (rising edge); rst_ni  in  1  asynchronous active-low reset.
REQ-005 data_i  in  DATA_W  input symbol.
REQ-006 last_i  in  1  marks final symbol of a stream.
REQ-007 vld_i  in  1  input valid.
REQ-008 rdy_o  out  1  input ready.
REQ-009 code_o  out  CODE_W  code word, right-aligned, MSB at bit len_o-1, unused upper bits zero.
REQ-010 len_o  out  LEN_W  code length in bits.
REQ-011 last_o  out  1  code is final code of the stream.
REQ-012 vld_o  out  1  output valid.
REQ-013 rdy_i  in  1  downstream ready.

Function
REQ-014 Transfers SHALL occur only on cycles where valid and ready are both high; vld_o SHALL not depend combinationally on rdy_i.
REQ-015 Code for a nonzero symbol v SHALL be '1' followed by v: code = {1'b1, v}, len = DATA_W+1.
REQ-016 Code for a zero run of n (1..MAX_RUN) SHALL be '0' followed by (n-1) in RUN_W bits, len = RUN_W+1.
REQ-017 Output SHALL be a single registered slot; out_free = slot empty OR rdy_i.
REQ-018 rdy_o SHALL equal out_free in states IDLE and RUN, and 0 in state SPLIT.
REQ-019 FSM states SHALL be IDLE (no pending zeros), RUN (cnt zeros pending, 1 <= cnt < MAX_RUN), SPLIT (run code emitted, nonzero symbol pending).
REQ-020 IDLE, accept zero, last_i=0: cnt <= 1, go to RUN, no emission.
REQ-021 IDLE, accept zero, last_i=1: emit run(1) with last_o=1, stay IDLE.
REQ-022 IDLE, accept nonzero: emit value code with last_o = last_i, stay IDLE.
REQ-023 RUN, accept zero: if cnt+1 == MAX_RUN or last_i, emit run(cnt+1) with last_o = last_i, cnt <= 0, go to IDLE; otherwise cnt <= cnt+1.
REQ-024 RUN, accept nonzero: emit run(cnt) with last_o=0, latch symbol and last_i into pending register, cnt <= 0, go to SPLIT.
REQ-025 SPLIT: when out_free, emit pending value code with pending last, go to IDLE.
REQ-026 Every emission SHALL load the slot in the same cycle; the slot SHALL hold code_o/len_o/last_o stable while vld_o=1 and rdy_i=0.
REQ-027 Latency SHALL be one cycle from accepting the terminating input to vld_o=1; sustained throughput SHALL be one code per cycle with rdy_i=1.
REQ-028 A run never exceeds MAX_RUN; reaching MAX_RUN SHALL emit immediately, with no wrap of cnt.

Reset
REQ-029 On rst_ni low, the block SHALL asynchronously force state IDLE, cnt 0, pending register 0, slot empty; vld_o=0, code_o=0, len_o=0, last_o=0.
REQ-030 Reset mid-run SHALL discard pending zeros and any slot content without emitting them.

Structure
REQ-031 State enum and code/len/last output struct type SHALL live in shared package ebpc_pkg.
REQ-032 The output slot SHALL be an instance of fifo_slice with t = the output struct.

Verification (DATA_W=8, RUN_W=4)
REQ-033 Inputs 0x05, 0x00, 0x00, 0x07(last) -> codes (0x105, 9), (0x01, 5), (0x107, 9, last).
REQ-034 20 zeros, last on the 20th -> (0x0F, 5), (0x03, 5, last).
REQ-035 Single zero with last -> (0x00, 5, last).
REQ-036 Slot full, rdy_i low for 10 cycles -> rdy_o=0, outputs stable, no loss or duplication.
REQ-037 3 zeros then reset pulse, then 0x09(last) -> only (0x109, 9, last) appears.
REQ-038 100 consecutive nonzero symbols with rdy_i=1 -> 100 codes on 100 consecutive cycles.
